// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: opcodes, FSM states
// and the opcode-to-cell-control mapping.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] CELL_AND = 2'b00;
  localparam logic [1:0] CELL_OR  = 2'b01;
  localparam logic [1:0] CELL_ADD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic       binvert;
    logic [1:0] cell_op;
  } cell_ctrl_t;

  // Unused encodings fold onto ADD (011) or SUB (100, 101); logic ops never invert B.
  function automatic cell_ctrl_t map_op(input logic [2:0] op);
    cell_ctrl_t c;
    c.binvert = 1'b0;
    c.cell_op = CELL_ADD;
    case (op)
      OP_AND:         c.cell_op = CELL_AND;
      OP_OR:          c.cell_op = CELL_OR;
      OP_ADD, 3'b011: c.cell_op = CELL_ADD;
      default: begin
        c.binvert = 1'b1;
        c.cell_op = CELL_ADD;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_1bit.sv
// One-bit ALU cell: AND, OR and full-add with optional B inversion.
module alu_1bit
  import alu_ctrl_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       binvert_i,
  input  logic       carry_i,
  input  logic [1:0] operation_i,
  output logic       result_o,
  output logic       carry_o
);

  logic b_eff_s;

  assign b_eff_s = b_i ^ binvert_i;
  assign carry_o = (a_i & b_eff_s) | (a_i & carry_i) | (b_eff_s & carry_i);

  // Result mux; logic ops see the raw B bit.
  always_comb begin
    result_o = 1'b0;
    case (operation_i)
      CELL_AND: result_o = a_i & b_i;
      CELL_OR:  result_o = a_i | b_i;
      CELL_ADD: result_o = a_i ^ b_eff_s ^ carry_i;
      default:  result_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial WIDTH-bit ALU: one alu_1bit cell driven LSB first, carry held in
// a register, result and flags registered when the MSB is processed.
module alu_serial_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_sh_q, res_sh_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;

  cell_ctrl_t       ctrl_s;
  logic             cell_res_s, cell_co_s, ovf_s;
  logic [WIDTH-1:0] final_s;

  assign ctrl_s = map_op(op_q);

  alu_1bit u_cell (
    .a_i         (a_sh_q[0]),
    .b_i         (b_sh_q[0]),
    .binvert_i   (ctrl_s.binvert),
    .carry_i     (carry_q),
    .operation_i (ctrl_s.cell_op),
    .result_o    (cell_res_s),
    .carry_o     (cell_co_s)
  );

  // Full result as it will stand after this bit, and overflow from the MSB carries.
  assign final_s = {cell_res_s, res_sh_q[WIDTH-1:1]};
  assign ovf_s   = carry_q ^ cell_co_s;

  // Next-state, datapath and output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    op_d     = op_q;
    carry_d  = carry_q;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = op;
          carry_d = map_op(op).binvert;
          cnt_d   = {CW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        res_sh_d = final_s;
        carry_d  = cell_co_s;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (ctrl_s.cell_op != CELL_ADD) begin
            result_d = final_s;
            cout_d   = 1'b0;
            ovf_d    = 1'b0;
          end else if (op_q == OP_SLT) begin
            result_d = {{(WIDTH-1){1'b0}}, final_s[WIDTH-1] ^ ovf_s};
            cout_d   = cell_co_s;
            ovf_d    = ovf_s;
          end else begin
            result_d = final_s;
            cout_d   = cell_co_s;
            ovf_d    = ovf_s;
          end
          zero_d = (result_d == {WIDTH{1'b0}});
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d != RUN);
    busy_d  = (state_d == RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      a_sh_q   <= {WIDTH{1'b0}};
      b_sh_q   <= {WIDTH{1'b0}};
      res_sh_q <= {WIDTH{1'b0}};
      op_q     <= 3'b000;
      carry_q  <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: directed vector table, multi-cycle
// corner sequences and random operations against an arithmetic reference model.
module tb_alu_serial_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0, b = '0;
  logic         ready, busy, done, zero, carry_out, overflow;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .result(result),
    .zero(zero), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] res;
    logic         z, c, v;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on whole words.
  task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic z, output logic c, output logic v);
    logic [W:0] s;
    r = '0; c = 1'b0; v = 1'b0;
    if (o == 3'b000) r = x & y;
    else if (o == 3'b001) r = x | y;
    else if (o == 3'b010 || o == 3'b011) begin
      s = {1'b0, x} + {1'b0, y};
      r = s[W-1:0];
      c = s[W];
      v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r = x - y;
      c = (x >= y);
      v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      if (o == 3'b111) r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
    end
    z = (r == '0);
  endtask

  // Called at a negedge with ready=1; returns at the negedge where done is seen.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit pulse_mid, output int lat);
    int k;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
    k = 0;
    lat = 0;
    forever begin
      @(posedge clk);
      #1 start = 1'b0;
      k++;
      @(negedge clk);
      if (done) begin
        lat = k + 1;
        break;
      end
      if (k > 4 * W) begin
        chk("done_timeout", 64'd0, 64'd1);
        break;
      end
      if (pulse_mid && k == 3) begin
        start = 1'b1; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
      end
    end
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] o,
                               input logic [W-1:0] x, input logic [W-1:0] y, input int lat);
    logic [W-1:0] r;
    logic z, c, v;
    model(o, x, y, r, z, c, v);
    chk({tag, "_latency"}, 64'(lat), 64'(W + 1));
    chk({tag, "_result"}, 64'(result), 64'(r));
    chk({tag, "_flags"}, {61'd0, zero, carry_out, overflow}, {61'd0, z, c, v});
    chk({tag, "_ready"}, 64'(ready), 64'd1);
  endtask

  initial begin
    int lat;
    int nd;
    logic [2:0] ro;
    logic [W-1:0] ra, rb;

    vecs[0] = '{3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{3'b110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{3'b111, 8'h80, 8'h01, 8'h01, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{3'b111, 8'h01, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{3'b001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{3'b011, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_status", {61'd0, ready, busy, done}, {61'd0, 3'b100});
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_flags", {61'd0, zero, carry_out, overflow}, 64'd0);

    // Directed vector table, each op started from IDLE.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(W + 1));
      chk($sformatf("vec%0d_result", i), 64'(result), 64'(vecs[i].res));
      chk($sformatf("vec%0d_flags", i), {61'd0, zero, carry_out, overflow},
          {61'd0, vecs[i].z, vecs[i].c, vecs[i].v});
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), {62'd0, done, ready}, 64'd1);
    end

    // Inputs scrambled and start pulsed mid-run: latched op only, single done.
    issue(3'b010, 8'h10, 8'h20, 1'b1, lat);
    check_outputs("midrun", 3'b010, 8'h10, 8'h20, lat);
    nd = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("midrun_not_queued", 64'(nd), 64'd0);
    chk("midrun_result_held", 64'(result), 64'h30);

    // Back-to-back: start accepted in the DONE cycle.
    issue(3'b010, 8'h01, 8'h02, 1'b0, lat);
    check_outputs("b2b_first", 3'b010, 8'h01, 8'h02, lat);
    issue(3'b110, 8'h03, 8'h09, 1'b0, lat);
    check_outputs("b2b_second", 3'b110, 8'h03, 8'h09, lat);
    @(negedge clk);

    // Reset mid-run aborts without a done pulse.
    start = 1'b1; op = 3'b010; a = 8'h44; b = 8'h11;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_status", {61'd0, ready, busy, done}, {61'd0, 3'b100});
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_flags", {61'd0, zero, carry_out, overflow}, 64'd0);
    nd = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done || !ready) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);

    // Random operations, randomly back-to-back, against the model.
    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom);
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        ra = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h7F;
      end
      issue(ro, ra, rb, ($urandom_range(0, 4) == 0), lat);
      check_outputs($sformatf("rnd%0d_op%0d", n, ro), ro, ra, rb, lat);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
